wave_renderer: RTL and testbench
================================

Name: wave_renderer

Overview:
- Downstream pixel stage of the VGA timing controller; consumes its sync, valid and half-resolution counters (320x240 logical grid).
- Captures a stream of 8-bit waveform samples into a ping-pong sample buffer, one sample per logical column.
- Renders the front buffer as a connected trace over a centre axis and emits 12-bit RGB with sync delayed to match.
- Buffer swap happens only at vsync assertion, so each frame shows one coherent capture.

Parameters:
- COLS, 320, logical columns = samples per buffer
- ROWS, 240, logical rows
- TRACE_COLOR, 12'h0F0, trace pixel colour
- AXIS_COLOR, 12'h444, centre-axis colour
- BG_COLOR, 12'h000, background colour
- AXIS_ROW, 120, logical row of the axis line

Ports:
- pclk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- valid_in  in  1  active-video flag from timing controller
- hsync_in  in  1  hsync from timing controller, active low
- vsync_in  in  1  vsync from timing controller, active low
- h_cnt_div  in  9  logical column 0..319 (0 during blanking)
- v_cnt_div  in  9  logical row 0..239 (0 during blanking)
- sample_valid  in  1  sample strobe, one write per high cycle
- sample_data  in  8  unsigned sample, 0 = bottom, 255 = top
- sample_ready  out  1  back buffer not full (~buf_full)
- buf_full  out  1  back buffer holds COLS samples
- swap_pulse  out  1  one-cycle pulse when front/back swap
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}
- hsync_out  out  1  hsync_in delayed 2 cycles
- vsync_out  out  1  vsync_in delayed 2 cycles
- valid_out  out  1  valid_in delayed 2 cycles

Behaviour:
- Reset values: rgb=0, hsync_out=1, vsync_out=1, valid_out=0, buf_full=0, sample_ready=1, swap_pulse=0. Internally wr_ptr=0, front_sel=0, vsync_d=1.
- Sample RAM contents are not reset. Output is defined only after the first swap.
- Storage: two COLS x 8 buffers. front_sel selects the display buffer; the other buffer is the back buffer.
- Write path: on sample_valid && !buf_full, write sample_data to back[wr_ptr] and increment wr_ptr.
  - When wr_ptr reaches COLS-1 and a write occurs, set buf_full=1; wr_ptr stays at COLS.
  - Samples arriving while buf_full=1 are dropped silently.
- Swap trigger: vsync_d && !vsync_in (vsync falling edge, registered detect) while buf_full=1.
  - Toggle front_sel, clear wr_ptr to 0 and buf_full to 0.
  - swap_pulse is high for exactly that cycle.
- Swap without full: a vsync edge with buf_full=0 does nothing; capture continues into the same back buffer.
- Swap and write in the same cycle: the swap wins. The sample is written to index 0 of the new back buffer (the old front) and wr_ptr becomes 1.
  - Buffer-full gate for that write uses the pre-swap state: the write is dropped if buf_full was 1.
- Read pipeline, stage 1: synchronous read front[h_cnt_div]. Register v_cnt_div, valid, hsync, vsync, and the col==0 flag.
- Read pipeline, stage 2: s = read data; yt = ((255-s)*15)>>4, range 0..239 (s=255 -> 0, s=128 -> 119, s=0 -> 239).
  - yp = yt of the previous column. At column 0, yp = yt.
  - Pixel is trace if min(yt,yp) <= row <= max(yt,yp).
  - Else axis if row == AXIS_ROW. Else background.
- Latency: exactly 2 pclk from inputs to rgb/hsync_out/vsync_out/valid_out, with all four aligned.
- rgb = 0 whenever the stage-2 valid is 0 (blanking is forced black regardless of colour parameters).
- Arithmetic: (255-s)*15 needs 12 bits; compare yt/yp/row as 9-bit unsigned.
- Reset mid-frame: outputs return to reset values the next cycle. A partial capture is discarded (wr_ptr=0) and front_sel returns to 0.

Test Plan:
- Reset held 3 cycles, then released with vsync_in=1 and no samples -> rgb=0, hsync_out=1, vsync_out=1, valid_out=0, buf_full=0, sample_ready=1.
- Write 320 samples of 128, then drive one vsync falling edge -> buf_full=1 after the 320th write. swap_pulse is high one cycle after the edge. Next frame: row 119 is 12'h0F0 for all columns, row 120 is 12'h444, row 0 is 12'h000.
- Continuous sample_valid for 330 cycles with no vsync edge -> exactly 320 writes accepted, sample_ready=0 from cycle 321, samples 321..330 never appear on screen.
- Buffer with col 10 = 255 and col 11 = 0 (others 128), swapped -> column 11 trace covers rows 0..239. Column 10 covers rows 0..119.
- Toggle hsync_in, vsync_in and valid_in with known patterns -> hsync_out, vsync_out and valid_out equal the inputs delayed exactly 2 cycles, and rgb=0 wherever valid_out=0.
- sample_valid coincident with the vsync edge while buf_full=1 -> swap occurs, that sample is dropped, wr_ptr=0. A sample on the next cycle lands at index 0.

Source files
------------

// File: rtl/wave_renderer.sv
// wave_renderer: captures 8-bit waveform samples into a ping-pong buffer
// and renders the front buffer as a connected trace over a centre axis.
//
// Ports:
//   pclk, reset          pixel clock, synchronous active-high reset
//   valid_in             active-video flag from the timing controller
//   hsync_in, vsync_in   active-low syncs from the timing controller
//   h_cnt_div            logical column 0..COLS-1
//   v_cnt_div            logical row 0..ROWS-1
//   sample_valid         one sample write per high cycle
//   sample_data          unsigned sample, 0 = bottom, 255 = top
//   sample_ready         back buffer can accept samples (~buf_full)
//   buf_full             back buffer holds COLS samples
//   swap_pulse           one-cycle pulse after a front/back swap
//   rgb                  12-bit pixel {R,G,B}, black when not valid
//   hsync_out            hsync_in delayed 2 cycles
//   vsync_out            vsync_in delayed 2 cycles
//   valid_out            valid_in delayed 2 cycles

module wave_renderer #(
    parameter int          COLS        = 320,
    parameter int          ROWS        = 240,
    parameter logic [11:0] TRACE_COLOR = 12'h0F0,
    parameter logic [11:0] AXIS_COLOR  = 12'h444,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter int          AXIS_ROW    = 120
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [8:0]  h_cnt_div,
    input  logic [8:0]  v_cnt_div,
    input  logic        sample_valid,
    input  logic [7:0]  sample_data,
    output logic        sample_ready,
    output logic        buf_full,
    output logic        swap_pulse,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        valid_out
);

    // Sample storage, not reset
    logic [7:0] mem0_q [COLS];
    logic [7:0] mem1_q [COLS];

    // Capture / swap control
    logic [8:0] wr_ptr_q, wr_ptr_d;
    logic       buf_full_q, buf_full_d;
    logic       front_sel_q, front_sel_d;
    logic       vsync_dly_q, vsync_dly_d;
    logic       swap_pulse_q, swap_pulse_d;
    logic       swap;
    logic       wr_en;
    logic       we0, we1;
    logic [8:0] wr_idx;

    // Stage 1
    logic [8:0] rd_idx, prv_idx;
    logic [7:0] cur_q, cur_d;
    logic [7:0] prv_q, prv_d;
    logic [8:0] row1_q, row1_d;
    logic       valid1_q, valid1_d;
    logic       hs1_q, hs1_d;
    logic       vs1_q, vs1_d;
    logic       col0_q, col0_d;

    // Stage 2
    logic [11:0] rgb_q, rgb_d;
    logic        hs2_q, hs2_d;
    logic        vs2_q, vs2_d;
    logic        valid2_q, valid2_d;
    logic [8:0]  yt, yp, yp_raw, lo, hi;
    logic        row_ok;

    // Screen row of a sample: 255 maps to the top row, 0 to row 239
    function automatic logic [8:0] row_of(input logic [7:0] s);
        return 9'((12'(8'd255 - s) * 12'd15) >> 4);
    endfunction

    always_comb begin
        swap        = vsync_dly_q && !vsync_in && buf_full_q;
        wr_en       = sample_valid && !buf_full_q;
        front_sel_d = front_sel_q ^ swap;
        vsync_dly_d = vsync_in;
        swap_pulse_d = swap;
        wr_ptr_d    = wr_ptr_q;
        buf_full_d  = buf_full_q;
        // On a swap any write goes to slot 0 of the new back buffer
        wr_idx      = swap ? 9'd0 : wr_ptr_q;
        if (swap) begin
            wr_ptr_d   = wr_en ? 9'd1 : 9'd0;
            buf_full_d = 1'b0;
        end else if (wr_en) begin
            wr_ptr_d   = wr_ptr_q + 9'd1;
            buf_full_d = (wr_ptr_q == 9'(COLS - 1));
        end
        // Back buffer is the one not selected for display
        we0 = wr_en && front_sel_d;
        we1 = wr_en && !front_sel_d;
    end

    always_ff @(posedge pclk) begin
        if (we0) mem0_q[wr_idx] <= sample_data;
        if (we1) mem1_q[wr_idx] <= sample_data;
    end

    always_comb begin
        rd_idx  = (h_cnt_div < 9'(COLS)) ? h_cnt_div : 9'd0;
        // Column 0 reads itself as its own predecessor
        prv_idx = (rd_idx == 9'd0) ? 9'd0 : rd_idx - 9'd1;
        cur_d   = front_sel_q ? mem1_q[rd_idx] : mem0_q[rd_idx];
        prv_d   = front_sel_q ? mem1_q[prv_idx] : mem0_q[prv_idx];
        row1_d   = v_cnt_div;
        valid1_d = valid_in;
        hs1_d    = hsync_in;
        vs1_d    = vsync_in;
        col0_d   = (h_cnt_div == 9'd0);
    end

    always_ff @(posedge pclk) begin
        cur_q <= cur_d;
        prv_q <= prv_d;
    end

    always_comb begin
        yt     = row_of(cur_q);
        yp_raw = row_of(prv_q);
        yp     = col0_q ? yt : yp_raw;
        lo     = (yt < yp) ? yt : yp;
        hi     = (yt < yp) ? yp : yt;
        row_ok = (row1_q < 9'(ROWS));
        rgb_d  = 12'h000;
        if (valid1_q) begin
            if (row_ok && row1_q >= lo && row1_q <= hi)
                rgb_d = TRACE_COLOR;
            else if (row_ok && row1_q == 9'(AXIS_ROW))
                rgb_d = AXIS_COLOR;
            else
                rgb_d = BG_COLOR;
        end
        hs2_d    = hs1_q;
        vs2_d    = vs1_q;
        valid2_d = valid1_q;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            wr_ptr_q     <= 9'd0;
            buf_full_q   <= 1'b0;
            front_sel_q  <= 1'b0;
            vsync_dly_q  <= 1'b1;
            swap_pulse_q <= 1'b0;
            row1_q       <= 9'd0;
            valid1_q     <= 1'b0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            col0_q       <= 1'b0;
            rgb_q        <= 12'h000;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
            valid2_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            buf_full_q   <= buf_full_d;
            front_sel_q  <= front_sel_d;
            vsync_dly_q  <= vsync_dly_d;
            swap_pulse_q <= swap_pulse_d;
            row1_q       <= row1_d;
            valid1_q     <= valid1_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            col0_q       <= col0_d;
            rgb_q        <= rgb_d;
            hs2_q        <= hs2_d;
            vs2_q        <= vs2_d;
            valid2_q     <= valid2_d;
        end
    end

    assign buf_full     = buf_full_q;
    assign sample_ready = ~buf_full_q;
    assign swap_pulse   = swap_pulse_q;
    assign rgb          = rgb_q;
    assign hsync_out    = hs2_q;
    assign vsync_out    = vs2_q;
    assign valid_out    = valid2_q;

endmodule

// File: tb/tb_wave_renderer.sv
// tb_wave_renderer: random and directed stimulus for wave_renderer,
// checked every cycle against a frame-level behavioural model.

module tb_wave_renderer;

    localparam int COLS = 320;

    logic        pclk = 1'b0;
    logic        reset;
    logic        valid_in, hsync_in, vsync_in;
    logic [8:0]  h_cnt_div, v_cnt_div;
    logic        sample_valid;
    logic [7:0]  sample_data;
    logic        sample_ready, buf_full, swap_pulse;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, valid_out;

    int n_vec = 0;
    int n_bad = 0;

    wave_renderer dut (
        .pclk        (pclk),
        .reset       (reset),
        .valid_in    (valid_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .h_cnt_div   (h_cnt_div),
        .v_cnt_div   (v_cnt_div),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .sample_ready(sample_ready),
        .buf_full    (buf_full),
        .swap_pulse  (swap_pulse),
        .rgb         (rgb),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .valid_out   (valid_out)
    );

    always #5 pclk = ~pclk;

    // Model state: two buffers with per-entry "written" flags
    logic [7:0]  mb [2][COLS];
    bit          kn [2][COLS];
    int          mfront, mcount;
    bit          mfull, mvs_prev, mpulse;
    // Two-entry output pipe; index 1 is what the outputs show now
    logic [11:0] p_rgb [2];
    bit          p_hs [2], p_vs [2], p_va [2], p_kn [2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         tag, got, exp, $time);
        end
    endtask

    function automatic int yrow(int s);
        return ((255 - s) * 15) / 16;
    endfunction

    function automatic logic [11:0] pix(int h, int v);
        int yt, yp, lo, hi;
        yt = yrow(int'(mb[mfront][h]));
        yp = (h == 0) ? yt : yrow(int'(mb[mfront][h-1]));
        lo = (yt < yp) ? yt : yp;
        hi = (yt < yp) ? yp : yt;
        if (v >= lo && v <= hi) return 12'h0F0;
        if (v == 120) return 12'h444;
        return 12'h000;
    endfunction

    function automatic bit pix_known(int h);
        return kn[mfront][h] && (h == 0 || kn[mfront][h-1]);
    endfunction

    task automatic model_edge();
        bit fell, swp, acc;
        int h;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                p_rgb[i] = 12'h000; p_hs[i] = 1; p_vs[i] = 1;
                p_va[i] = 0; p_kn[i] = 1;
            end
            mfront = 0; mcount = 0; mfull = 0;
            mvs_prev = 1; mpulse = 0;
        end else begin
            h = int'(h_cnt_div);
            p_rgb[1] = p_rgb[0]; p_hs[1] = p_hs[0]; p_vs[1] = p_vs[0];
            p_va[1] = p_va[0]; p_kn[1] = p_kn[0];
            p_hs[0] = hsync_in; p_vs[0] = vsync_in; p_va[0] = valid_in;
            if (valid_in) begin
                p_rgb[0] = pix(h, int'(v_cnt_div));
                p_kn[0] = pix_known(h);
            end else begin
                p_rgb[0] = 12'h000;
                p_kn[0] = 1;
            end
            fell = mvs_prev && !vsync_in;
            swp = fell && mfull;
            acc = sample_valid && !mfull;
            mvs_prev = vsync_in;
            mpulse = swp;
            if (swp) begin
                mfront = 1 - mfront; mcount = 0; mfull = 0;
            end
            if (acc) begin
                mb[1-mfront][mcount] = sample_data;
                kn[1-mfront][mcount] = 1;
                mcount++;
                if (mcount == COLS) mfull = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        model_edge();
        @(negedge pclk);
        chk("hsync_out", 32'(hsync_out), 32'(p_hs[1]));
        chk("vsync_out", 32'(vsync_out), 32'(p_vs[1]));
        chk("valid_out", 32'(valid_out), 32'(p_va[1]));
        if (p_kn[1]) chk("rgb", 32'(rgb), 32'(p_rgb[1]));
        chk("buf_full", 32'(buf_full), 32'(mfull));
        chk("sample_ready", 32'(sample_ready), 32'(!mfull));
        chk("swap_pulse", 32'(swap_pulse), 32'(mpulse));
    endtask

    task automatic idle();
        valid_in = 0; hsync_in = 1; vsync_in = 1;
        h_cnt_div = 0; v_cnt_div = 0;
        sample_valid = 0; sample_data = 0;
    endtask

    task automatic vs_edge();
        vsync_in = 0; cyc();
        vsync_in = 1; cyc();
    endtask

    task automatic scan_row(input int r);
        for (int h = 0; h < COLS; h++) begin
            h_cnt_div = 9'(h); v_cnt_div = 9'(r); valid_in = 1;
            cyc();
        end
        valid_in = 0; h_cnt_div = 0; v_cnt_div = 0;
        cyc(); cyc();
    endtask

    initial begin
        reset = 1;
        idle();
        repeat (3) cyc();
        reset = 0;
        repeat (4) cyc();

        // Flat mid-scale capture
        sample_valid = 1; sample_data = 8'd128;
        for (int i = 0; i < COLS; i++) cyc();
        sample_valid = 0; cyc();
        vs_edge();
        scan_row(119); scan_row(120); scan_row(0);

        // Overrun: 330 strobes, only 320 kept
        sample_valid = 1;
        for (int i = 0; i < 330; i++) begin
            sample_data = 8'($urandom); cyc();
        end
        sample_valid = 0; cyc();
        vs_edge();
        scan_row($urandom_range(0, 239));
        scan_row($urandom_range(0, 239));

        // Full-swing step between columns 10 and 11
        sample_valid = 1;
        for (int i = 0; i < COLS; i++) begin
            sample_data = (i == 10) ? 8'd255 : (i == 11) ? 8'd0 : 8'd128;
            cyc();
        end
        sample_valid = 0; cyc();
        vs_edge();
        scan_row(0); scan_row(119); scan_row(200); scan_row(239);

        // Sample coincident with the swap edge
        sample_valid = 1;
        for (int i = 0; i < COLS; i++) begin
            sample_data = 8'($urandom); cyc();
        end
        vsync_in = 0; sample_data = 8'h11; cyc();
        vsync_in = 1; sample_data = 8'h22; cyc();
        sample_data = 8'd128;
        for (int i = 1; i < COLS; i++) cyc();
        sample_valid = 0; cyc();
        vs_edge();
        scan_row(207); scan_row(119);

        // Known sync/valid patterns, no samples
        for (int i = 0; i < 300; i++) begin
            hsync_in = ((i % 7) < 2) ? 1'b0 : 1'b1;
            vsync_in = ((i % 50) < 3) ? 1'b0 : 1'b1;
            valid_in = ((i % 5) != 0) ? 1'b1 : 1'b0;
            h_cnt_div = 9'($urandom_range(0, COLS - 1));
            v_cnt_div = 9'($urandom_range(0, 239));
            cyc();
        end
        idle(); cyc();

        // Random mix with occasional mid-frame reset
        for (int i = 0; i < 8000; i++) begin
            reset = ($urandom_range(0, 1999) == 0);
            sample_valid = ($urandom_range(0, 4) != 0);
            sample_data = 8'($urandom);
            vsync_in = ($urandom_range(0, 299) != 0);
            hsync_in = ($urandom_range(0, 9) != 0);
            valid_in = ($urandom_range(0, 3) != 0);
            h_cnt_div = 9'($urandom_range(0, COLS - 1));
            v_cnt_div = 9'($urandom_range(0, 239));
            cyc();
        end
        reset = 0;
        idle();
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
